// File: rtl/mips_timer_pkg.sv
// Shared definitions for the memory-mapped down-counter timer:
// register offsets, CTRL field positions, mode encodings and FSM states.
package mips_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_W    = 4;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_e;

    // Only the exact auto-reload code reloads; 1x falls back to one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/mips_timer_if.sv
// Word-addressed data-bus port of the timer peripheral.
interface mips_timer_if;

    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata,
        output irq
    );

endinterface

// File: rtl/mips_timer.sv
// Down-counter timer: counts PRESET to zero, raises irq, one-shot or
// auto-reload. Registers CTRL, PRESET and read-only COUNT.
import mips_timer_pkg::*;

module mips_timer #(
    parameter int               CNT_W        = 32,
    parameter logic [CNT_W-1:0] RESET_PRESET = '0
) (
    input  logic       clk,
    input  logic       reset,
    mips_timer_if.slave bus
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  preset_q, preset_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_e            state_q, state_d;
    logic              pend_q, pend_d;

    logic       en;
    logic [1:0] mode;
    logic       im;
    logic       wr_ctrl;
    logic       wr_preset;

    assign en        = ctrl_q[CTRL_EN];
    assign mode      = ctrl_q[CTRL_MODE +: 2];
    assign im        = ctrl_q[CTRL_IM];
    assign wr_ctrl   = bus.we && (bus.addr == REG_CTRL);
    assign wr_preset = bus.we && (bus.addr == REG_PRESET);

    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        state_d  = state_q;
        pend_d   = pend_q;

        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (count_q == '0) begin
                    state_d = S_INT;
                    pend_d  = 1'b1;
                end else begin
                    count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                if (is_reload(mode)) begin
                    pend_d  = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = S_IDLE;
                end
            end
        endcase

        // A CPU write to CTRL overrides the FSM's own EN clear.
        if (wr_ctrl) begin
            ctrl_d = bus.wdata[CTRL_W-1:0];
            pend_d = 1'b0;
        end
        if (wr_preset) preset_d = bus.wdata[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            preset_q <= RESET_PRESET;
            count_q  <= '0;
            state_q  <= S_IDLE;
            pend_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        case (bus.addr)
            REG_CTRL:   bus.rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
            REG_PRESET: bus.rdata = 32'(preset_q);
            REG_COUNT:  bus.rdata = 32'(count_q);
            default:    bus.rdata = 32'd0;
        endcase
    end

    assign bus.irq = im & pend_q;

endmodule

// File: tb/tb_mips_timer.sv
// Directed bench for mips_timer: reset, one-shot, auto-reload, masking,
// pause/preset edits and corner cases with hand-computed expectations.
module tb_mips_timer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mips_timer_if bus();

    mips_timer #(
        .CNT_W(32),
        .RESET_PRESET(32'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a,
                          input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'd0, bus.irq}, {31'd0, exp});
    endtask

    int highs;
    int expc;

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.addr  = 2'd0;
        bus.we    = 1'b0;
        bus.wdata = 32'd0;
        tick(2);
        reset = 1'b0;
        tick(1);

        chk_irq("rst_irq", 1'b0);
        chk_rd("rst_ctrl", 2'd0, 32'd0);
        chk_rd("rst_preset", 2'd1, 32'd0);
        chk_rd("rst_count", 2'd2, 32'd0);

        // Reset mid-count
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick(4);
        chk_rd("mid_count3", 2'd2, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk_irq("mid_rst_irq", 1'b0);
        chk_rd("mid_rst_count", 2'd2, 32'd0);
        chk_rd("mid_rst_ctrl", 2'd0, 32'd0);
        chk_rd("mid_rst_preset", 2'd1, 32'd0);
        reset = 1'b0;
        tick(1);

        // One-shot
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick(2);
        chk_rd("os_count5", 2'd2, 32'd5);
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk("os_count", bus.rdata, 32'(5 - k));
        end
        chk_irq("os_irq_e7", 1'b0);
        tick(1);
        chk_irq("os_irq_e8", 1'b1);
        tick(1);
        chk_rd("os_ctrl_en0", 2'd0, 32'h8);
        chk_irq("os_irq_e9", 1'b1);
        tick(3);
        chk_irq("os_irq_hold", 1'b1);
        wr(2'd0, 32'd0);
        chk_irq("os_irq_clr", 1'b0);

        // Auto-reload: period 5
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        highs = 0;
        for (int k = 1; k <= 25; k++) begin
            tick(1);
            if (bus.irq === 1'b1) highs++;
            if (k == 5) chk_irq("ar_irq_e5", 1'b1);
            if (k == 6) chk_irq("ar_irq_e6", 1'b0);
            if (k == 9) chk_irq("ar_irq_e9", 1'b0);
            if (k == 10) chk_irq("ar_irq_e10", 1'b1);
        end
        chk("ar_pulses", 32'(highs), 32'd5);
        wr(2'd0, 32'd0);
        chk_irq("ar_stop", 1'b0);
        tick(3);

        // Masked interrupt
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        tick(6);
        chk_irq("mask_irq", 1'b0);
        chk_rd("mask_ctrl", 2'd0, 32'd0);
        wr(2'd0, 32'h8);
        chk_irq("mask_im_irq", 1'b0);
        tick(1);
        chk_irq("mask_im_irq2", 1'b0);
        wr(2'd0, 32'd0);

        // Pause, preset edit, count write
        wr(2'd1, 32'd6);
        wr(2'd0, 32'h1);
        tick(4);
        chk_rd("pz_count4", 2'd2, 32'd4);
        wr(2'd1, 32'd7);
        chk_rd("pz_count3", 2'd2, 32'd3);
        chk_rd("pz_preset7", 2'd1, 32'd7);
        wr(2'd0, 32'd0);
        tick(3);
        chk_rd("pz_frozen", 2'd2, 32'd2);
        wr(2'd2, 32'h55);
        chk_rd("pz_cnt_wr", 2'd2, 32'd2);
        wr(2'd0, 32'h1);
        tick(2);
        chk_rd("pz_reload7", 2'd2, 32'd7);
        wr(2'd0, 32'd0);
        tick(2);

        // Corners
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick(2);
        chk_irq("p0_irq_e2", 1'b0);
        tick(1);
        chk_irq("p0_irq_e3", 1'b1);
        chk_rd("rsvd_read", 2'd3, 32'd0);
        wr(2'd0, 32'h9);
        chk_rd("int_wr_ctrl", 2'd0, 32'h9);
        chk_irq("int_wr_irq", 1'b0);
        tick(3);
        chk_irq("int_wr_rerun", 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_irq("rst_irq_drop", 1'b0);
        chk_rd("rst_ctrl2", 2'd0, 32'd0);
        reset = 1'b0;
        tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
